// File: rtl/multi_alarm_clock_core_pkg.sv
// Shared encodings, limits and BCD helpers for the multi-alarm clock core.
package multi_alarm_clock_core_pkg;

   // Operating modes as presented on the mode input; 2'b11 behaves like RUN.
   typedef enum logic [1:0] {
      MODE_RUN       = 2'b00,
      MODE_SET_TIME  = 2'b01,
      MODE_SET_ALARM = 2'b10,
      MODE_RUN_ALT   = 2'b11
   } mode_e;

   // Alarm ring state machine.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RING   = 2'd1,
      ST_SNOOZE = 2'd2
   } state_e;

   // Largest legal BCD values for minutes/seconds and hours.
   localparam logic [7:0] BCD_MAX_MS = 8'h59;
   localparam logic [7:0] BCD_MAX_H  = 8'h23;

   // Minute counter width, enough for 1..59.
   localparam int CNT_W = 6;

   // Width of a slot index; a single slot still gets one (ignored) bit.
   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Two-digit BCD increment that wraps to 00 after max_v.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
      if (v == max_v)
         return 8'h00;
      else if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

endpackage

// File: rtl/multi_alarm_clock_core_if.sv
// Control/status bundle between the button/strobe front end and the clock core.
interface multi_alarm_clock_core_if
   import multi_alarm_clock_core_pkg::*;
#(
   parameter int NUM_ALARMS = 4,
   parameter int LED_W      = 16
);
   localparam int SEL_W = sel_w(NUM_ALARMS);

   logic                  tick_1hz;
   logic [1:0]            mode;
   logic [SEL_W-1:0]      alarm_sel;
   logic                  inc_hour;
   logic                  inc_min;
   logic [NUM_ALARMS-1:0] alarm_en;
   logic                  stop;
   logic                  snooze;
   logic [23:0]           time_bcd;
   logic [15:0]           disp_bcd;
   logic                  ringing;
   logic [SEL_W-1:0]      ring_id;
   logic [LED_W-1:0]      led;

   modport master (
      output tick_1hz, mode, alarm_sel, inc_hour, inc_min, alarm_en, stop, snooze,
      input  time_bcd, disp_bcd, ringing, ring_id, led
   );

   modport slave (
      input  tick_1hz, mode, alarm_sel, inc_hour, inc_min, alarm_en, stop, snooze,
      output time_bcd, disp_bcd, ringing, ring_id, led
   );
endinterface

// File: rtl/multi_alarm_clock_core_bcd_hhmm_reg.sv
// HH:MM BCD register: button steps without hour carry, carry_in with hour carry.
module bcd_hhmm_reg
   import multi_alarm_clock_core_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       inc_min,
   input  logic       inc_hour,
   input  logic       carry_in,
   output logic [7:0] hh,
   output logic [7:0] mm,
   output logic [7:0] hh_next,
   output logic [7:0] mm_next
);
   logic [7:0] hh_q, hh_d;
   logic [7:0] mm_q, mm_d;

   // Next HH:MM; only a seconds carry ripples from minutes into hours.
   always_comb begin
      mm_d = mm_q;
      hh_d = hh_q;
      if (inc_min || carry_in)
         mm_d = bcd_inc(mm_q, BCD_MAX_MS);
      if (inc_hour || (carry_in && (mm_q == BCD_MAX_MS)))
         hh_d = bcd_inc(hh_q, BCD_MAX_H);
   end

   // HH:MM state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hh_q <= 8'h00;
         mm_q <= 8'h00;
      end else begin
         hh_q <= hh_d;
         mm_q <= mm_d;
      end
   end

   assign hh      = hh_q;
   assign mm      = mm_q;
   assign hh_next = hh_d;
   assign mm_next = mm_d;
endmodule

// File: rtl/multi_alarm_clock_core.sv
// Timekeeping core: HH:MM:SS counter, NUM_ALARMS alarm slots, ring/snooze FSM.
module multi_alarm_clock_core
   import multi_alarm_clock_core_pkg::*;
#(
   parameter int NUM_ALARMS       = 4,
   parameter int SNOOZE_MIN       = 5,
   parameter int RING_TIMEOUT_MIN = 10,
   parameter int LED_W            = 16
)(
   input  logic                     clk,
   input  logic                     rst,
   multi_alarm_clock_core_if.slave  bus
);
   localparam int SEL_W = sel_w(NUM_ALARMS);

   logic run_mode, set_time, set_alarm, count_en;
   logic sec_wrap, min_roll;

   // Time keeps running in every mode except SET_TIME; alarms match in RUN only.
   assign run_mode  = (bus.mode == MODE_RUN) || (bus.mode == MODE_RUN_ALT);
   assign set_time  = (bus.mode == MODE_SET_TIME);
   assign set_alarm = (bus.mode == MODE_SET_ALARM);
   assign count_en  = !set_time;

   // ---------------- seconds stage ----------------
   logic [7:0] ss_q, ss_d;

   assign sec_wrap = count_en && bus.tick_1hz && (ss_q == BCD_MAX_MS);
   assign min_roll = run_mode && sec_wrap;

   // Seconds advance on the strobe, and clear when minutes are set by hand.
   always_comb begin
      ss_d = ss_q;
      if (set_time && bus.inc_min)
         ss_d = 8'h00;
      else if (count_en && bus.tick_1hz)
         ss_d = bcd_inc(ss_q, BCD_MAX_MS);
   end

   // ---------------- time HH:MM ----------------
   logic [7:0] t_hh, t_mm, t_hh_nx, t_mm_nx;

   bcd_hhmm_reg u_time (
      .clk      (clk),
      .rst      (rst),
      .inc_min  (set_time && bus.inc_min),
      .inc_hour (set_time && bus.inc_hour),
      .carry_in (sec_wrap),
      .hh       (t_hh),
      .mm       (t_mm),
      .hh_next  (t_hh_nx),
      .mm_next  (t_mm_nx)
   );

   // ---------------- alarm slots ----------------
   logic [7:0] al_hh    [NUM_ALARMS];
   logic [7:0] al_mm    [NUM_ALARMS];
   logic [7:0] al_hh_nx [NUM_ALARMS];
   logic [7:0] al_mm_nx [NUM_ALARMS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_ALARMS; gi++) begin : g_alarm
         logic edit_sel;
         assign edit_sel = set_alarm && ((NUM_ALARMS == 1) || (bus.alarm_sel == SEL_W'(gi)));

         bcd_hhmm_reg u_alarm (
            .clk      (clk),
            .rst      (rst),
            .inc_min  (edit_sel && bus.inc_min),
            .inc_hour (edit_sel && bus.inc_hour),
            .carry_in (1'b0),
            .hh       (al_hh[gi]),
            .mm       (al_mm[gi]),
            .hh_next  (al_hh_nx[gi]),
            .mm_next  (al_mm_nx[gi])
         );
      end
   endgenerate

   // Compare enabled slots with the HH:MM being loaded; lowest index wins.
   logic             match_hit;
   logic [SEL_W-1:0] match_idx;
   always_comb begin
      match_hit = 1'b0;
      match_idx = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (bus.alarm_en[i] && (al_hh[i] == t_hh_nx) && (al_mm[i] == t_mm_nx)) begin
            match_hit = 1'b1;
            match_idx = SEL_W'(i);
         end
      end
   end

   // Display follows the value being loaded so it lines up with time_bcd.
   logic [15:0] disp_q, disp_d;
   logic [7:0]  sel_hh, sel_mm;
   always_comb begin
      sel_hh = al_hh_nx[0];
      sel_mm = al_mm_nx[0];
      for (int i = 1; i < NUM_ALARMS; i++) begin
         if (bus.alarm_sel == SEL_W'(i)) begin
            sel_hh = al_hh_nx[i];
            sel_mm = al_mm_nx[i];
         end
      end
      disp_d = set_alarm ? {sel_hh, sel_mm} : {t_hh_nx, t_mm_nx};
   end

   // ---------------- ring / snooze FSM ----------------
   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SEL_W-1:0]  ring_id_q, ring_id_d;
   logic [LED_W-1:0]  led_q, led_d;
   logic              ringing;
   logic              abort;

   // Leaving RUN or disabling the ringing slot drops back to IDLE.
   assign abort = !run_mode || !bus.alarm_en[ring_id_q];

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         ring_id_q <= '0;
         led_q     <= '0;
         ss_q      <= 8'h00;
         disp_q    <= 16'h0000;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ring_id_q <= ring_id_d;
         led_q     <= led_d;
         ss_q      <= ss_d;
         disp_q    <= disp_d;
      end
   end

   // Next state; stop outranks snooze, and cnt_q holds minutes still to wait.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:
            if (min_roll && match_hit) state_d = ST_RING;
         ST_RING:
            if (abort || bus.stop)                  state_d = ST_IDLE;
            else if (bus.snooze)                    state_d = ST_SNOOZE;
            else if (min_roll && cnt_q == CNT_W'(1)) state_d = ST_IDLE;
         ST_SNOOZE:
            if (abort || bus.stop)                  state_d = ST_IDLE;
            else if (min_roll && cnt_q == CNT_W'(1)) state_d = ST_RING;
         default:
            state_d = ST_IDLE;
      endcase
   end

   // Outputs and counters; both ring timeout and snooze count down to the event.
   always_comb begin
      cnt_d     = cnt_q;
      ring_id_d = ring_id_q;
      led_d     = led_q;
      ringing   = (state_q == ST_RING);
      case (state_d)
         ST_RING: begin
            if (state_q != ST_RING) begin
               led_d = '1;
               cnt_d = CNT_W'(RING_TIMEOUT_MIN);
               if (state_q == ST_IDLE) ring_id_d = match_idx;
            end else begin
               if (bus.tick_1hz) led_d = ~led_q;
               if (min_roll)     cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_SNOOZE: begin
            led_d = '0;
            if (state_q != ST_SNOOZE) cnt_d = CNT_W'(SNOOZE_MIN);
            else if (min_roll)        cnt_d = cnt_q - CNT_W'(1);
         end
         default: begin
            led_d     = '0;
            cnt_d     = '0;
            ring_id_d = '0;
         end
      endcase
   end

   assign bus.time_bcd = {t_hh, t_mm, ss_q};
   assign bus.disp_bcd = disp_q;
   assign bus.ringing  = ringing;
   assign bus.ring_id  = ring_id_q;
   assign bus.led      = led_q;
endmodule

// File: tb/tb_multi_alarm_clock_core.sv
// Directed bench for multi_alarm_clock_core with hand-computed expectations.
module tb_multi_alarm_clock_core;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   multi_alarm_clock_core_if #(.NUM_ALARMS(4), .LED_W(16)) bus ();

   multi_alarm_clock_core #(
      .NUM_ALARMS(4), .SNOOZE_MIN(5), .RING_TIMEOUT_MIN(10), .LED_W(16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_btn(input logic h, input logic m);
      bus.inc_hour = h;
      bus.inc_min  = m;
      cyc();
      bus.inc_hour = 1'b0;
      bus.inc_min  = 1'b0;
   endtask

   task automatic press(input int nh, input int nm);
      for (int i = 0; i < nh; i++) pulse_btn(1'b1, 1'b0);
      for (int i = 0; i < nm; i++) pulse_btn(1'b0, 1'b1);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         bus.tick_1hz = 1'b1;
         cyc();
         bus.tick_1hz = 1'b0;
      end
   endtask

   task automatic ctrl(input logic st, input logic sn);
      bus.stop   = st;
      bus.snooze = sn;
      cyc();
      bus.stop   = 1'b0;
      bus.snooze = 1'b0;
   endtask

   initial begin
      bus.tick_1hz  = 1'b0;
      bus.mode      = 2'b00;
      bus.alarm_sel = 2'd0;
      bus.inc_hour  = 1'b0;
      bus.inc_min   = 1'b0;
      bus.alarm_en  = 4'b0000;
      bus.stop      = 1'b0;
      bus.snooze    = 1'b0;
      cyc();
      cyc();
      check("reset_time", 32'(bus.time_bcd), 32'h000000);
      check("reset_disp", 32'(bus.disp_bcd), 32'h0000);
      check("reset_ringing", 32'(bus.ringing), 32'h0);
      check("reset_ring_id", 32'(bus.ring_id), 32'h0);
      check("reset_led", 32'(bus.led), 32'h0000);
      rst = 1'b0;
      cyc();

      // SET_TIME editing and wrap rules
      bus.mode = 2'b01;
      press(23, 59);
      check("set_2359", 32'(bus.time_bcd), 32'h235900);
      press(0, 1);
      check("min_wrap_no_carry", 32'(bus.time_bcd), 32'h230000);
      press(1, 0);
      check("hour_wrap", 32'(bus.time_bcd), 32'h000000);
      pulse_btn(1'b1, 1'b1);
      check("both_buttons", 32'(bus.time_bcd), 32'h010100);
      press(22, 58);
      check("set_2359_again", 32'(bus.time_bcd), 32'h235900);
      check("disp_set_time", 32'(bus.disp_bcd), 32'h2359);

      // Day rollover in RUN
      bus.mode = 2'b00;
      ticks(59);
      check("pre_rollover", 32'(bus.time_bcd), 32'h235959);
      ticks(1);
      check("rollover", 32'(bus.time_bcd), 32'h000000);
      check("rollover_disp", 32'(bus.disp_bcd), 32'h0000);

      // Seconds frozen in SET_TIME, inc_min clears seconds
      ticks(5);
      bus.mode = 2'b01;
      ticks(1);
      check("sec_frozen", 32'(bus.time_bcd), 32'h000005);
      press(0, 1);
      check("inc_min_clears_sec", 32'(bus.time_bcd), 32'h000100);

      // Program alarms 0 and 2 to 06:30
      bus.mode = 2'b10;
      bus.alarm_sel = 2'd0;
      press(6, 30);
      check("disp_alarm0", 32'(bus.disp_bcd), 32'h0630);
      bus.alarm_sel = 2'd2;
      press(6, 30);
      check("disp_alarm2", 32'(bus.disp_bcd), 32'h0630);
      bus.alarm_sel = 2'd1;
      cyc();
      check("disp_alarm1_untouched", 32'(bus.disp_bcd), 32'h0000);
      bus.mode = 2'b01;
      press(6, 28);
      check("set_0629", 32'(bus.time_bcd), 32'h062900);

      // Priority match: slot 0 wins over slot 2
      bus.alarm_en = 4'b0101;
      bus.mode = 2'b00;
      ticks(59);
      check("no_ring_before", 32'(bus.ringing), 32'h0);
      ticks(1);
      check("match_ringing", 32'(bus.ringing), 32'h1);
      check("match_ring_id", 32'(bus.ring_id), 32'h0);
      check("match_led_on", 32'(bus.led), 32'hFFFF);
      check("match_time", 32'(bus.time_bcd), 32'h063000);
      ticks(1);
      check("led_toggle_off", 32'(bus.led), 32'h0000);
      ticks(1);
      check("led_toggle_on", 32'(bus.led), 32'hFFFF);

      // Snooze for five minute rollovers
      ctrl(1'b0, 1'b1);
      check("snooze_ringing", 32'(bus.ringing), 32'h0);
      check("snooze_led", 32'(bus.led), 32'h0000);
      ticks(57 + 4 * 60);
      check("snooze_4min", 32'(bus.ringing), 32'h0);
      check("snooze_4min_time", 32'(bus.time_bcd), 32'h063459);
      ticks(1);
      check("snooze_rering", 32'(bus.ringing), 32'h1);
      check("snooze_ring_id", 32'(bus.ring_id), 32'h0);
      check("snooze_led_on", 32'(bus.led), 32'hFFFF);

      // Stop and snooze together: stop wins, no re-ring later
      ctrl(1'b1, 1'b1);
      check("collide_ringing", 32'(bus.ringing), 32'h0);
      ticks(301);
      check("collide_no_rering", 32'(bus.ringing), 32'h0);
      check("collide_led", 32'(bus.led), 32'h0000);

      // Unattended ring times out after ten rollovers (slot 3 at 06:41)
      bus.mode = 2'b10;
      bus.alarm_sel = 2'd3;
      press(6, 41);
      bus.alarm_en = 4'b1000;
      bus.mode = 2'b00;
      ticks(59);
      check("timeout_ring", 32'(bus.ringing), 32'h1);
      check("timeout_ring_id", 32'(bus.ring_id), 32'h3);
      ticks(599);
      check("timeout_9min", 32'(bus.ringing), 32'h1);
      ticks(1);
      check("timeout_idle", 32'(bus.ringing), 32'h0);
      check("timeout_led", 32'(bus.led), 32'h0000);

      // Disabling the ringing slot during SNOOZE aborts (slot 1 at 06:52)
      bus.mode = 2'b10;
      bus.alarm_sel = 2'd1;
      press(6, 52);
      bus.alarm_en = 4'b0010;
      bus.mode = 2'b00;
      ticks(60);
      check("slot1_ring", 32'(bus.ringing), 32'h1);
      check("slot1_ring_id", 32'(bus.ring_id), 32'h1);
      ctrl(1'b0, 1'b1);
      bus.alarm_en = 4'b0000;
      cyc();
      bus.alarm_en = 4'b0010;
      ticks(300);
      check("en_abort_no_rering", 32'(bus.ringing), 32'h0);
      check("en_abort_time", 32'(bus.time_bcd), 32'h065700);

      // Leaving RUN while ringing aborts (slot 2 moved to 06:58)
      bus.mode = 2'b10;
      bus.alarm_sel = 2'd2;
      press(0, 28);
      bus.alarm_en = 4'b0100;
      bus.mode = 2'b00;
      ticks(60);
      check("slot2_ring", 32'(bus.ringing), 32'h1);
      check("slot2_ring_id", 32'(bus.ring_id), 32'h2);
      bus.mode = 2'b01;
      cyc();
      bus.mode = 2'b00;
      ticks(1);
      check("mode_abort_ringing", 32'(bus.ringing), 32'h0);
      check("mode_abort_led", 32'(bus.led), 32'h0000);

      // Asynchronous reset mid-ring (slot 2 moved to 06:59)
      bus.mode = 2'b10;
      press(0, 1);
      bus.mode = 2'b00;
      ticks(59);
      check("pre_reset_ring", 32'(bus.ringing), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_ringing", 32'(bus.ringing), 32'h0);
      check("async_rst_led", 32'(bus.led), 32'h0000);
      check("async_rst_ring_id", 32'(bus.ring_id), 32'h0);
      check("async_rst_time", 32'(bus.time_bcd), 32'h000000);
      cyc();
      rst = 1'b0;
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
